// File: rtl/vr_seq_ctrl.sv
// Voltage-rail sequencer: brings four rails up in order with power-good timeouts,
// tears them down in reverse, and retries a bounded number of times before lockout.
//
// state | meaning
// ------+--------------------------------------------------------------
// OFF   | all rails off, waiting for PWR_REQ
// UP    | rails 0..idx enabled, waiting for power-good of rail idx
// ON    | all rails up and good, PWR_OK asserted
// DOWN  | orderly reverse shutdown on request
// FDOWN | reverse shutdown after a fault
// RWAIT | settle delay before an automatic retry
// LOCK  | retries exhausted, waiting for FAULT_CLR with PWR_REQ low
module vr_seq_ctrl #(
    parameter int T_TIMEOUT = 3300,
    parameter int T_OFF_DLY = 33,
    parameter int MAX_RETRY = 2
) (
    input  logic       CLK_33K_SUSCLK_PLD_R2,
    input  logic       RST_RSMRST_N,
    input  logic       PWR_REQ,
    input  logic [3:0] RAIL_PG,
    input  logic       FAULT_CLR,
    output logic [3:0] RAIL_EN,
    output logic       PWR_OK,
    output logic       FAULT,
    output logic [1:0] FAULT_RAIL,
    output logic       FAULT_TYPE,
    output logic [1:0] RETRY_CNT,
    output logic [2:0] SEQ_STATE
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_UP    = 3'd1,
        S_ON    = 3'd2,
        S_DOWN  = 3'd3,
        S_FDOWN = 3'd4,
        S_RWAIT = 3'd5,
        S_LOCK  = 3'd6
    } state_t;

    localparam logic [15:0] TO_LAST   = 16'(T_TIMEOUT - 1);
    localparam logic [15:0] OFF_LAST  = 16'(T_OFF_DLY - 1);
    localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);

    state_t      state, state_nx;
    logic [1:0]  idx, idx_nx;
    logic [15:0] timer;
    logic [3:0]  en_nx;
    logic [1:0]  retry_nx;
    logic [1:0]  frail_nx;
    logic        ftype_nx;
    logic [3:0]  below_mask, drop_low;
    logic        pg_cur, tmo, off_dly_done, fdown_done, timer_clr;

    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        lowest_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) lowest_idx = 2'(i);
        end
    endfunction

    function automatic logic [3:0] clear_top(input logic [3:0] v);
        clear_top = v;
        if (v[3])      clear_top[3] = 1'b0;
        else if (v[2]) clear_top[2] = 1'b0;
        else if (v[1]) clear_top[1] = 1'b0;
        else           clear_top[0] = 1'b0;
    endfunction

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        en_nx        = RAIL_EN;
        retry_nx     = RETRY_CNT;
        frail_nx     = FAULT_RAIL;
        ftype_nx     = FAULT_TYPE;
        fdown_done   = 1'b0;
        below_mask   = (4'b0001 << idx) - 4'b0001;
        drop_low     = ~RAIL_PG & below_mask;
        pg_cur       = RAIL_PG[idx];
        tmo          = (timer == TO_LAST);
        off_dly_done = (timer == OFF_LAST);

        case (state)
            S_OFF: begin
                if (PWR_REQ) begin
                    state_nx = S_UP;
                    idx_nx   = 2'd0;
                    en_nx    = 4'b0001;
                end
            end
            S_UP: begin
                // Faults outrank a request drop, which outranks progress.
                if (drop_low != 4'b0000) begin
                    state_nx = S_FDOWN;
                    en_nx    = clear_top(RAIL_EN);
                    frail_nx = lowest_idx(drop_low);
                    ftype_nx = 1'b1;
                end else if (!pg_cur && tmo) begin
                    state_nx = S_FDOWN;
                    en_nx    = clear_top(RAIL_EN);
                    frail_nx = idx;
                    ftype_nx = 1'b0;
                end else if (!PWR_REQ) begin
                    state_nx = S_DOWN;
                    en_nx    = clear_top(RAIL_EN);
                end else if (pg_cur) begin
                    if (idx == 2'd3) begin
                        state_nx = S_ON;
                    end else begin
                        idx_nx = idx + 2'd1;
                        en_nx  = RAIL_EN | (4'b0010 << idx);
                    end
                end
            end
            S_ON: begin
                if (RAIL_PG != 4'b1111) begin
                    state_nx = S_FDOWN;
                    en_nx    = clear_top(RAIL_EN);
                    frail_nx = lowest_idx(~RAIL_PG);
                    ftype_nx = 1'b1;
                end else if (!PWR_REQ) begin
                    state_nx = S_DOWN;
                    en_nx    = clear_top(RAIL_EN);
                end
            end
            S_DOWN: begin
                if (off_dly_done) begin
                    if (RAIL_EN == 4'b0000) state_nx = S_OFF;
                    else                    en_nx    = clear_top(RAIL_EN);
                end
            end
            S_FDOWN: begin
                if (RAIL_EN == 4'b0000) begin
                    fdown_done = 1'b1;
                end else if (off_dly_done) begin
                    en_nx      = clear_top(RAIL_EN);
                    fdown_done = (en_nx == 4'b0000);
                end
            end
            S_RWAIT: begin
                if (off_dly_done) begin
                    if (PWR_REQ) begin
                        state_nx = S_UP;
                        idx_nx   = 2'd0;
                        en_nx    = 4'b0001;
                    end else begin
                        state_nx = S_OFF;
                    end
                end
            end
            S_LOCK: begin
                en_nx = 4'b0000;
                if (FAULT_CLR && !PWR_REQ) state_nx = S_OFF;
            end
            default: begin
                state_nx = S_OFF;
                en_nx    = 4'b0000;
            end
        endcase

        if (fdown_done) begin
            if (RETRY_CNT < RETRY_MAX) begin
                state_nx = S_RWAIT;
                retry_nx = RETRY_CNT + 2'd1;
            end else begin
                state_nx = S_LOCK;
            end
        end
        if (state_nx == S_OFF && state != S_OFF) retry_nx = 2'd0;

        // Any rail-enable change restarts the timer so shutdown steps are evenly spaced.
        timer_clr = (state_nx != state) || (idx_nx != idx) || (en_nx != RAIL_EN);
    end

    always_ff @(posedge CLK_33K_SUSCLK_PLD_R2 or negedge RST_RSMRST_N) begin
        if (!RST_RSMRST_N) begin
            state      <= S_OFF;
            idx        <= 2'd0;
            timer      <= 16'd0;
            RAIL_EN    <= 4'b0000;
            PWR_OK     <= 1'b0;
            FAULT      <= 1'b0;
            FAULT_RAIL <= 2'd0;
            FAULT_TYPE <= 1'b0;
            RETRY_CNT  <= 2'd0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            RAIL_EN    <= en_nx;
            PWR_OK     <= (state_nx == S_ON);
            FAULT      <= (state_nx == S_LOCK);
            FAULT_RAIL <= frail_nx;
            FAULT_TYPE <= ftype_nx;
            RETRY_CNT  <= retry_nx;
            if (timer_clr)               timer <= 16'd0;
            else if (timer != 16'hFFFF)  timer <= timer + 16'd1;
        end
    end

    assign SEQ_STATE = state;

endmodule

// File: tb/tb_vr_seq_ctrl.sv
// Bench for vr_seq_ctrl: directed scenarios plus random traffic, all compared
// cycle by cycle against a rail-count based reference model.
module tb_vr_seq_ctrl;

    localparam int TT = 8;
    localparam int TD = 2;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pwr_req = 1'b0;
    logic [3:0] rail_pg = 4'b0000;
    logic       fault_clr = 1'b0;
    logic [3:0] rail_en;
    logic       pwr_ok, fault, fault_type;
    logic [1:0] fault_rail, retry_cnt;
    logic [2:0] seq_state;

    int n_checks = 0;
    int n_fail = 0;

    // reference model: mode uses the published debug codes, on = count of enabled rails
    int m_mode, m_on, m_retry, m_frail, m_ftype, m_t, cyc;

    // rail environment: each rail reports good dly[i] clocks after its enable
    int  age[4];
    int  dly[4];
    bit  drop[4];
    bit  rand_mode = 1'b0;

    vr_seq_ctrl #(.T_TIMEOUT(TT), .T_OFF_DLY(TD), .MAX_RETRY(MR)) dut (
        .CLK_33K_SUSCLK_PLD_R2(clk),
        .RST_RSMRST_N(rst_n),
        .PWR_REQ(pwr_req),
        .RAIL_PG(rail_pg),
        .FAULT_CLR(fault_clr),
        .RAIL_EN(rail_en),
        .PWR_OK(pwr_ok),
        .FAULT(fault),
        .FAULT_RAIL(fault_rail),
        .FAULT_TYPE(fault_type),
        .RETRY_CNT(retry_cnt),
        .SEQ_STATE(seq_state)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] dut_vec();
        return {rail_en, pwr_ok, fault, fault_rail, fault_type, retry_cnt, seq_state};
    endfunction

    function automatic logic [13:0] exp_vec();
        logic [3:0] en;
        en = 4'((1 << m_on) - 1);
        return {en, m_mode == 2, m_mode == 6, 2'(m_frail), 1'(m_ftype), 2'(m_retry), 3'(m_mode)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_on = 0; m_retry = 0; m_frail = 0; m_ftype = 0; m_t = 0; cyc = 0;
    endtask

    task automatic model_fault(input int ty, input int rl);
        m_ftype = ty; m_frail = rl; m_mode = 4; m_on--; m_t = cyc;
    endtask

    task automatic model_fdown_done();
        if (m_retry < MR) begin m_mode = 5; m_retry++; end
        else m_mode = 6;
        m_t = cyc;
    endtask

    task automatic model_step();
        int el, cur, low;
        cyc++;
        el = cyc - m_t;
        case (m_mode)
            0: if (pwr_req) begin m_mode = 1; m_on = 1; m_t = cyc; end
            1: begin
                cur = m_on - 1;
                low = -1;
                for (int j = 0; j < cur; j++) if (!rail_pg[j] && low < 0) low = j;
                if (low >= 0) model_fault(1, low);
                else if (!rail_pg[cur] && el >= TT) model_fault(0, cur);
                else if (!pwr_req) begin m_mode = 3; m_on--; m_t = cyc; end
                else if (rail_pg[cur]) begin
                    if (cur == 3) m_mode = 2; else m_on++;
                    m_t = cyc;
                end
            end
            2: begin
                low = -1;
                for (int j = 0; j < 4; j++) if (!rail_pg[j] && low < 0) low = j;
                if (low >= 0) model_fault(1, low);
                else if (!pwr_req) begin m_mode = 3; m_on--; m_t = cyc; end
            end
            3: if (el >= TD) begin
                if (m_on == 0) begin m_mode = 0; m_retry = 0; end
                else m_on--;
                m_t = cyc;
            end
            4: begin
                if (m_on == 0) model_fdown_done();
                else if (el >= TD) begin
                    m_on--; m_t = cyc;
                    if (m_on == 0) model_fdown_done();
                end
            end
            5: if (el >= TD) begin
                if (pwr_req) begin m_mode = 1; m_on = 1; end
                else begin m_mode = 0; m_retry = 0; end
                m_t = cyc;
            end
            6: if (fault_clr && !pwr_req) begin m_mode = 0; m_retry = 0; m_t = cyc; end
            default: m_mode = 0;
        endcase
    endtask

    task automatic drive_pg();
        for (int i = 0; i < 4; i++)
            rail_pg[i] = rail_en[i] && (age[i] >= dly[i]) && !drop[i];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rail_en[i]) age[i]++;
            else begin
                age[i] = 0;
                if (rand_mode) dly[i] = $urandom_range(1, 9);
            end
        end
        drive_pg();
    endtask

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() !== 14'h0) begin
            n_fail++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), 14'h0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin age[i] = 0; drop[i] = 1'b0; end
        drive_pg();
        tick();
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL idle_after_reset got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_power_up();
        set_dly(3, 3, 3, 3);
        pwr_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL power_up cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({rail_en, pwr_ok} !== 5'b1111_1) begin
            n_fail++; $display("FAIL power_up_final en/ok got=%b exp=%b", {rail_en, pwr_ok}, 5'b11111);
        end
    endtask

    task automatic test_power_down();
        pwr_req = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL power_down cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({rail_en, seq_state} !== 7'd0) begin
            n_fail++; $display("FAIL power_down_final got=%b exp=%b", {rail_en, seq_state}, 7'd0);
        end
    endtask

    task automatic test_pg_at_timeout();
        set_dly(3, TT, 3, 3);
        pwr_req = 1'b1;
        for (int k = 0; k < 22; k++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL pg_at_timeout cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({pwr_ok, fault} !== 2'b10) begin
            n_fail++; $display("FAIL pg_at_timeout_on got=%b exp=%b", {pwr_ok, fault}, 2'b10);
        end
    endtask

    task automatic test_dual_dropout();
        set_dly(3, 3, 3, 3);
        drop[1] = 1'b1; drop[3] = 1'b1;
        drive_pg();
        tick();
        n_checks++;
        if ({fault_rail, fault_type, pwr_ok, rail_en} !== {2'd1, 1'b1, 1'b0, 4'h7}) begin
            n_fail++; $display("FAIL dual_dropout got=%b exp=%b",
                               {fault_rail, fault_type, pwr_ok, rail_en}, {2'd1, 1'b1, 1'b0, 4'h7});
        end
        drop[1] = 1'b0; drop[3] = 1'b0;
        drive_pg();
        for (int k = 0; k < 40; k++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL dropout_retry cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        pwr_req = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL dropout_down cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_timeout_lock();
        set_dly(3, 3, 1000, 3);
        pwr_req = 1'b1;
        for (int k = 0; k < 150 && m_mode != 6; k++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL timeout_seq cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({fault, rail_en, fault_rail, fault_type, retry_cnt} !== {1'b1, 4'h0, 2'd2, 1'b0, 2'd2}) begin
            n_fail++; $display("FAIL timeout_lock got=%b exp=%b",
                               {fault, rail_en, fault_rail, fault_type, retry_cnt},
                               {1'b1, 4'h0, 2'd2, 1'b0, 2'd2});
        end
    endtask

    task automatic test_lock_clear();
        fault_clr = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL lock_hold cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if (seq_state !== 3'd6) begin
            n_fail++; $display("FAIL lock_ignores_clr got=%0d exp=6", seq_state);
        end
        pwr_req = 1'b0;
        tick();
        fault_clr = 1'b0;
        n_checks++;
        if ({seq_state, retry_cnt, fault} !== {3'd0, 2'd0, 1'b0}) begin
            n_fail++; $display("FAIL lock_clear got=%b exp=%b", {seq_state, retry_cnt, fault}, 6'd0);
        end
    endtask

    task automatic test_reset_mid_up();
        int k;
        set_dly(3, 20, 3, 3);
        pwr_req = 1'b1;
        for (k = 0; k < 20 && rail_en !== 4'h3; k++) tick();
        n_checks++;
        if (rail_en !== 4'h3) begin
            n_fail++; $display("FAIL mid_up_wait got=%h exp=3", rail_en);
        end
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() !== 14'h0) begin
            n_fail++; $display("FAIL reset_mid_up got=%h exp=%h", dut_vec(), 14'h0);
        end
        pwr_req = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin age[i] = 0; drop[i] = 1'b0; end
        drive_pg();
    endtask

    task automatic test_random();
        rand_mode = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) pwr_req = ~pwr_req;
            fault_clr = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 4; i++) begin
                if (drop[i]) begin
                    if ($urandom_range(0, 5) == 0) drop[i] = 1'b0;
                end else if ($urandom_range(0, 149) == 0) begin
                    drop[i] = 1'b1;
                end
            end
            drive_pg();
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin age[i] = 0; dly[i] = 3; drop[i] = 1'b0; end
        model_reset();
        test_reset();
        test_power_up();
        test_power_down();
        test_pg_at_timeout();
        test_dual_dropout();
        test_timeout_lock();
        test_lock_clear();
        test_reset_mid_up();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vr_seq_ctrl.md
VR_SEQ_CTRL -- requirements
Module: vr_seq_ctrl

Interface
REQ-001 Parameter T_TIMEOUT, default 3300, max clocks to wait for a rail's power-good after its enable (100 ms at 33 kHz); 1..65535.
REQ-002 Parameter T_OFF_DLY, default 33, clocks between successive rail disables during shutdown (1 ms); 1..65535.
REQ-003 Parameter MAX_RETRY, default 2, automatic re-sequence attempts after a fault before lockout; 0..3.
REQ-004 CLK_33K_SUSCLK_PLD_R2  in  1  sole clock, all state on rising edge.
REQ-005 RST_RSMRST_N  in  1  reset, asynchronous assert, active-low.
REQ-006 PWR_REQ  in  1  level request for main power (from master sequencer); synchronous to clock.
REQ-007 RAIL_PG  in  4  power-good of rails 0..3, bit i pairs with RAIL_EN[i].
REQ-008 FAULT_CLR  in  1  clears lockout; honoured only with PWR_REQ=0.
REQ-009 RAIL_EN  out  4  registered rail enables, rail 0 first on, last off.
REQ-010 PWR_OK  out  1  registered; high only in state ON.
REQ-011 FAULT  out  1  registered; high only in state LOCK.
REQ-012 FAULT_RAIL  out  2  index of the rail in the most recent fault.
REQ-013 FAULT_TYPE  out  1  0 = power-good timeout, 1 = power-good dropout.
REQ-014 RETRY_CNT  out  2  retries consumed since last clean OFF.
REQ-015 SEQ_STATE  out  3  encoded state for debug pins: OFF=0, UP=1, ON=2, DOWN=3, FDOWN=4, RWAIT=5, LOCK=6.

Function
REQ-016 Single FSM, 16-bit timer, 2-bit rail index idx; timer clears on every state change and every idx change.
REQ-017 OFF: RAIL_EN=0; PWR_REQ=1 -> UP, idx=0; RAIL_EN[0] rises on the same edge that enters UP (1-cycle latency from PWR_REQ sampled high).
REQ-018 UP: RAIL_PG[idx]=1 sampled -> if idx=3 go ON, else idx+1 and set RAIL_EN[idx+1] on that edge.
REQ-019 UP: timer reaching T_TIMEOUT-1 with RAIL_PG[idx]=0 -> FDOWN, FAULT_TYPE=0, FAULT_RAIL=idx.
REQ-020 UP: RAIL_PG[j]=0 for any j<idx -> FDOWN, FAULT_TYPE=1, FAULT_RAIL=lowest such j.
REQ-021 UP or ON with PWR_REQ=0 and no fault that cycle -> DOWN.
REQ-022 ON: any RAIL_PG bit low -> FDOWN, FAULT_TYPE=1, FAULT_RAIL=lowest low index; PWR_OK drops on that edge.
REQ-023 DOWN/FDOWN: clear highest set RAIL_EN bit on entry, then one further bit each T_OFF_DLY clocks, descending; rails never enabled are skipped with no delay.
REQ-024 DOWN: last bit cleared -> OFF after T_OFF_DLY clocks.
REQ-025 FDOWN: last bit cleared -> if RETRY_CNT<MAX_RETRY then RWAIT and RETRY_CNT+1 on that edge, else LOCK.
REQ-026 RWAIT: wait T_OFF_DLY clocks; then PWR_REQ=1 -> UP (idx=0, RAIL_EN[0]=1), PWR_REQ=0 -> OFF.
REQ-027 LOCK: RAIL_EN=0; FAULT_CLR=1 and PWR_REQ=0 -> OFF; FAULT_CLR with PWR_REQ=1 ignored.
REQ-028 RETRY_CNT clears on every entry to OFF; saturates, never wraps.
REQ-029 Priority same cycle: PG arrival beats timeout; fault beats PWR_REQ drop; dropout on lower rail beats event on current rail.
REQ-030 FAULT_RAIL/FAULT_TYPE hold last captured value until next fault or reset.
REQ-031 PWR_REQ changes in DOWN/FDOWN are ignored until sequence completes.
REQ-032 RAIL_PG is assumed pre-synchronized; no internal debounce.

Reset
REQ-033 RST_RSMRST_N low asynchronously forces OFF, RAIL_EN=0, PWR_OK=0, FAULT=0, FAULT_RAIL=0, FAULT_TYPE=0, RETRY_CNT=0, SEQ_STATE=0, timer=0, idx=0, including mid-sequence.
REQ-034 After release, first state change occurs no earlier than the first rising edge with RST_RSMRST_N high.

Verification (bench params T_TIMEOUT=8, T_OFF_DLY=2, MAX_RETRY=2)
REQ-035 PWR_REQ=1, each RAIL_PG[i] rises 3 clocks after RAIL_EN[i] -> RAIL_EN 1,3,7,F at 3-clock spacing, PWR_OK=1 one edge after PG[3].
REQ-036 From ON, PWR_REQ=0 -> RAIL_EN F,7,3,1,0 at 2-clock spacing, OFF 2 clocks later, PWR_OK=0 on first edge.
REQ-037 RAIL_PG[2] stuck low -> after 8 clocks FAULT_RAIL=2, FAULT_TYPE=0, two retries (RETRY_CNT 1,2), third timeout -> LOCK, FAULT=1, RAIL_EN=0.
REQ-038 In ON, drop RAIL_PG[1] and RAIL_PG[3] same cycle -> FAULT_RAIL=1, FAULT_TYPE=1, PWR_OK=0 next edge, RAIL_EN reverse shutdown.
REQ-039 LOCK with PWR_REQ=1, FAULT_CLR=1 -> stays LOCK; PWR_REQ=0, FAULT_CLR=1 -> OFF, RETRY_CNT=0.
REQ-040 Assert RST_RSMRST_N low mid-UP (RAIL_EN=3) -> all outputs zero immediately, no clock needed.
